// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, IF/ID slot with valid/ready, redirect, EBREAK halt and fault.
// Optional FETCH_PERF_CNT_EN adds a fetch_count capture counter.
module fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMEM_AW  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [IMEM_AW-1:0] imem_address,
   input  logic [31:0]        imem_instr,
   input  logic               id_ready,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   output logic [31:0]        if_pc,
   output logic               halted,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        fetch_count,
`endif
   output logic               fault
);

   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_HALT  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        if_valid_q;
   logic [31:0] if_instr_q;
   logic [31:0] if_pc_q;
   logic        halted_q;
   logic        fault_q;

   logic [31:0] pc_d;
   logic        slot_free_d;
   logic        pc_oor_d;
   logic        redir_misaligned_d;
   logic        capture_d;

   assign pc_d               = pc_q + 32'd4;
   assign slot_free_d        = !if_valid_q || id_ready;
   assign pc_oor_d           = (pc_q >> (IMEM_AW + 2)) != 32'd0;
   assign redir_misaligned_d = redirect_pc[1:0] != 2'b00;
   // A capture happens only in RUN when nothing of higher priority claims the cycle.
   assign capture_d          = (state_q == S_RUN) && !redirect_valid && !pc_oor_d && slot_free_d;

   assign imem_address = pc_q[IMEM_AW+1:2];
   assign if_valid     = if_valid_q;
   assign if_instr     = if_instr_q;
   assign if_pc        = if_pc_q;
   assign halted       = halted_q;
   assign fault        = fault_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= INSTR_NOP;
         if_pc_q    <= 32'h0000_0000;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            S_BOOT: begin
               state_q <= S_RUN;
            end
            S_RUN: begin
               if (redirect_valid) begin
                  if_valid_q <= 1'b0;
                  pc_q       <= redirect_pc;
                  if (redir_misaligned_d) begin
                     state_q <= S_FAULT;
                     fault_q <= 1'b1;
                  end
               end else if (pc_oor_d) begin
                  // Let decode consume the pending instruction before faulting.
                  if (slot_free_d) begin
                     state_q    <= S_FAULT;
                     fault_q    <= 1'b1;
                     if_valid_q <= 1'b0;
                  end
               end else if (slot_free_d) begin
                  if_instr_q <= imem_instr;
                  if_pc_q    <= pc_q;
                  if_valid_q <= 1'b1;
                  pc_q       <= pc_d;
                  if (imem_instr == INSTR_EBREAK) begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               if (redirect_valid) begin
                  if_valid_q <= 1'b0;
                  pc_q       <= redirect_pc;
                  halted_q   <= 1'b0;
                  if (redir_misaligned_d) begin
                     state_q <= S_FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end else if (if_valid_q && id_ready) begin
                  if_valid_q <= 1'b0;
               end
            end
            S_FAULT: begin
               if_valid_q <= 1'b0;
            end
            default: begin
               state_q    <= S_FAULT;
               fault_q    <= 1'b1;
               halted_q   <= 1'b0;
               if_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;

   assign fetch_count = fetch_count_q;

   // Counts every captured instruction, EBREAK included; wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count_q <= 32'd0;
      end else if (capture_d) begin
         fetch_count_q <= fetch_count_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus a randomized run against a behavioural model.
module tb_fetch_controller;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  imem_address;
   logic [31:0] imem_instr;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        halted;
   logic        fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   logic [31:0] mem [0:1023];
   int n_vec = 0;
   int n_err = 0;

   // Behavioural model of the fetch stage
   logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
   logic        m_valid;
   int          m_mode;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_address];

   fetch_controller #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_address   (imem_address),
      .imem_instr     (imem_instr),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .halted         (halted),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count    (fetch_count),
`endif
      .fault          (fault)
   );

   // Advance model by one cycle from the current inputs, then clock the DUT.
   task automatic step();
      logic free;
      logic [31:0] word;
      free = !m_valid || id_ready;
      if (!rst_n) begin
         m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_mode = M_BOOT; m_cnt = 32'h0;
      end else if (m_mode == M_BOOT) begin
         m_mode = M_RUN;
      end else if (m_mode == M_FAULT) begin
         m_valid = 1'b0;
      end else if (redirect_valid) begin
         m_valid = 1'b0;
         m_pc    = redirect_pc;
         m_mode  = (redirect_pc % 4 != 0) ? M_FAULT : M_RUN;
      end else if (m_mode == M_HALT) begin
         if (id_ready) m_valid = 1'b0;
      end else if (m_pc >= 32'd4096) begin
         if (free) begin
            m_mode  = M_FAULT;
            m_valid = 1'b0;
         end
      end else if (free) begin
         word    = mem[m_pc / 4];
         m_instr = word;
         m_ipc   = m_pc;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
         m_cnt   = m_cnt + 32'd1;
         if (word == EBREAK) m_mode = M_HALT;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      logic [11:0] imm;
      for (int i = 0; i < 1024; i++) begin
         imm    = 12'(i);
         mem[i] = {imm, 20'h00013};
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec += 6;
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
      if (if_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", if_instr, NOP); end
      if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", if_pc); end
      if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
      if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
      if (imem_address !== 10'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_address); end
`ifdef FETCH_PERF_CNT_EN
      n_vec++;
      if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
`endif
   endtask

   task automatic test_stream_stall();
      logic [31:0] exp_pc;
      do_reset();
      step();
      n_vec++;
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid: got %b want 0", if_valid); end
      for (int k = 0; k < 3; k++) begin
         step();
         exp_pc = 32'(4 * k);
         n_vec += 3;
         if (if_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid: got %b want 1", if_valid); end
         if (if_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc: got %h want %h", if_pc, exp_pc); end
         if (if_instr !== mem[k]) begin n_err++; $display("FAIL stream_instr: got %h want %h", if_instr, mem[k]); end
      end
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec += 3;
         if (if_pc !== 32'h8) begin n_err++; $display("FAIL stall_pc: got %h want 8", if_pc); end
         if (if_instr !== mem[2]) begin n_err++; $display("FAIL stall_instr: got %h want %h", if_instr, mem[2]); end
         if (imem_address !== 10'd3) begin n_err++; $display("FAIL stall_addr: got %h want 3", imem_address); end
      end
      id_ready = 1'b1;
      step();
      n_vec += 2;
      if (if_pc !== 32'hC) begin n_err++; $display("FAIL resume_pc: got %h want c", if_pc); end
      if (if_instr !== mem[3]) begin n_err++; $display("FAIL resume_instr: got %h want %h", if_instr, mem[3]); end
   endtask

   task automatic test_redirect();
      do_reset();
      repeat (4) step();
      id_ready = 1'b0;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      n_vec += 2;
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b want 0", if_valid); end
      if (imem_address !== 10'h10) begin n_err++; $display("FAIL redir_addr: got %h want 10", imem_address); end
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      step();
      n_vec += 3;
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL redir_cap_valid: got %b want 1", if_valid); end
      if (if_pc !== 32'h40) begin n_err++; $display("FAIL redir_cap_pc: got %h want 40", if_pc); end
      if (if_instr !== mem[16]) begin n_err++; $display("FAIL redir_cap_instr: got %h want %h", if_instr, mem[16]); end
   endtask

   task automatic test_ebreak();
      logic [31:0] saved;
      saved  = mem[5];
      mem[5] = EBREAK;
      do_reset();
      repeat (7) step();
      n_vec += 4;
      if (if_pc !== 32'h14) begin n_err++; $display("FAIL ebreak_pc: got %h want 14", if_pc); end
      if (if_instr !== EBREAK) begin n_err++; $display("FAIL ebreak_instr: got %h want %h", if_instr, EBREAK); end
      if (halted !== 1'b1) begin n_err++; $display("FAIL ebreak_halted: got %b want 1", halted); end
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL ebreak_valid: got %b want 1", if_valid); end
      repeat (3) begin
         step();
         n_vec += 3;
         if (if_valid !== 1'b0) begin n_err++; $display("FAIL halt_drain: got %b want 0", if_valid); end
         if (halted !== 1'b1) begin n_err++; $display("FAIL halt_hold: got %b want 1", halted); end
         if (imem_address !== 10'd6) begin n_err++; $display("FAIL halt_addr: got %h want 6", imem_address); end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      n_vec += 2;
      if (halted !== 1'b0) begin n_err++; $display("FAIL resume_halted: got %b want 0", halted); end
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL resume_valid: got %b want 0", if_valid); end
      step();
      n_vec += 2;
      if (if_pc !== 32'h100) begin n_err++; $display("FAIL resume_cap_pc: got %h want 100", if_pc); end
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL resume_cap_valid: got %b want 1", if_valid); end
      // Redirect while EBREAK is on the bus squashes it.
      do_reset();
      repeat (6) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      step();
      redirect_valid = 1'b0;
      step();
      n_vec += 2;
      if (halted !== 1'b0) begin n_err++; $display("FAIL squash_halted: got %b want 0", halted); end
      if (if_pc !== 32'h80) begin n_err++; $display("FAIL squash_pc: got %h want 80", if_pc); end
      mem[5] = saved;
   endtask

   task automatic test_misaligned();
      do_reset();
      repeat (2) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h22;
      step();
      n_vec += 2;
      if (fault !== 1'b1) begin n_err++; $display("FAIL misal_fault: got %b want 1", fault); end
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL misal_valid: got %b want 0", if_valid); end
      repeat (4) begin
         id_ready       = 1'($urandom_range(0, 1));
         redirect_valid = 1'($urandom_range(0, 1));
         redirect_pc    = $urandom & 32'h0000_0FFC;
         step();
         n_vec += 2;
         if (fault !== 1'b1) begin n_err++; $display("FAIL fault_sticky: got %b want 1", fault); end
         if (if_valid !== 1'b0) begin n_err++; $display("FAIL fault_valid: got %b want 0", if_valid); end
      end
      do_reset();
      n_vec++;
      if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clear: got %b want 0", fault); end
      repeat (2) step();
      n_vec += 2;
      if (if_pc !== 32'h0) begin n_err++; $display("FAIL restart_pc: got %h want 0", if_pc); end
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL restart_valid: got %b want 1", if_valid); end
   endtask

   task automatic test_out_of_range();
      do_reset();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFC;
      step();
      redirect_valid = 1'b0;
      n_vec++;
      if (imem_address !== 10'h3FF) begin n_err++; $display("FAIL oor_addr: got %h want 3ff", imem_address); end
      id_ready = 1'b0;
      step();
      n_vec += 3;
      if (if_pc !== 32'hFFC) begin n_err++; $display("FAIL oor_cap_pc: got %h want ffc", if_pc); end
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL oor_cap_valid: got %b want 1", if_valid); end
      if (imem_address !== 10'd0) begin n_err++; $display("FAIL oor_wrap_addr: got %h want 0", imem_address); end
      repeat (2) begin
         step();
         n_vec += 2;
         if (fault !== 1'b0) begin n_err++; $display("FAIL oor_hold_fault: got %b want 0", fault); end
         if (if_pc !== 32'hFFC) begin n_err++; $display("FAIL oor_hold_pc: got %h want ffc", if_pc); end
      end
      id_ready = 1'b1;
      step();
      n_vec += 2;
      if (fault !== 1'b1) begin n_err++; $display("FAIL oor_fault: got %b want 1", fault); end
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL oor_valid: got %b want 0", if_valid); end
`ifdef FETCH_PERF_CNT_EN
      n_vec++;
      if (fetch_count !== 32'd1) begin n_err++; $display("FAIL oor_count: got %0d want 1", fetch_count); end
`endif
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = ($urandom_range(0, 11) == 0) ? EBREAK : $urandom;
      end
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_n          = ($urandom_range(0, 59) != 0);
         id_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 19);
         if (r == 0)      redirect_pc = ($urandom & 32'h0000_0FFF) | 32'h1;
         else if (r == 1) redirect_pc = 32'h0000_2000;
         else if (r < 5)  redirect_pc = 32'h0000_0FF0 + 32'(4 * $urandom_range(0, 3));
         else             redirect_pc = $urandom & 32'h0000_0FFC;
         step();
         n_vec += 6;
         if (if_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, if_valid, m_valid); end
         if (if_instr !== m_instr) begin n_err++; $display("FAIL rnd_instr c=%0d: got %h want %h", c, if_instr, m_instr); end
         if (if_pc !== m_ipc) begin n_err++; $display("FAIL rnd_pc c=%0d: got %h want %h", c, if_pc, m_ipc); end
         if (halted !== (m_mode == M_HALT)) begin n_err++; $display("FAIL rnd_halted c=%0d: got %b want %b", c, halted, m_mode == M_HALT); end
         if (fault !== (m_mode == M_FAULT)) begin n_err++; $display("FAIL rnd_fault c=%0d: got %b want %b", c, fault, m_mode == M_FAULT); end
         if (imem_address !== m_pc[11:2]) begin n_err++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, imem_address, m_pc[11:2]); end
`ifdef FETCH_PERF_CNT_EN
         n_vec++;
         if (fetch_count !== m_cnt) begin n_err++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, fetch_count, m_cnt); end
`endif
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      fill_mem();
      #1;
      test_reset();
      test_stream_stall();
      test_redirect();
      test_ebreak();
      test_misaligned();
      test_out_of_range();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
